mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register of the 5-stage pipeline. Consumes the EXE/MEM register outputs and performs loads/stores over a request/acknowledge data-memory port. Stalls upstream until the memory answers, then registers the write-back data, destination and write enable for the WB stage. A watchdog aborts accesses the memory never acknowledges and flags the error.

---
 rtl/mem_wb_stage_pkg.sv | 12 +
 rtl/mem_req_fsm.sv | 110 +++++++++++
 rtl/mem_wb_stage.sv | 79 +++++++
 tb/tb_mem_wb_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline constants and small decode helpers for the memory/write-back stage.
package mem_wb_stage_pkg;

  localparam int DSIZE = 16;
  localparam int ASIZE = 4;

  // A store with memtoreg also set is still a store; only a pure load writes back memory data.
  function automatic logic is_load(input logic memwrite, input logic memtoreg);
    return memtoreg & ~memwrite;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: holds one outstanding request, stalls upstream, aborts on timeout.
//   state   | meaning
//   ST_IDLE | no request outstanding; non-memory ops pass straight through
//   ST_BUSY | request on dmem port, waiting for ack or watchdog expiry
module mem_req_fsm
  import mem_wb_stage_pkg::*;
#(
  parameter int DSIZE   = mem_wb_stage_pkg::DSIZE,
  parameter int ASIZE   = mem_wb_stage_pkg::ASIZE,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             memwrite_in,
  input  logic             memtoreg_in,
  input  logic             wen_in,
  input  logic             dmem_ack,
  output logic             stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DSIZE-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  output logic             err,
  output logic             pass_en,
  output logic             done_en,
  output logic [ASIZE-1:0] lat_waddr,
  output logic             lat_wen,
  output logic             lat_load
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          memop, start, abort;

  assign memop = memwrite_in | memtoreg_in;

  // Watchdog is a down-counter: loaded with TIMEOUT-1 on issue, abort at terminal count zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    done_en   = 1'b0;
    pass_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memop) begin
          stall     = 1'b1;
          start     = 1'b1;
          cnt_nxt   = CW'(TIMEOUT - 1);
          state_nxt = ST_BUSY;
        end else begin
          pass_en = 1'b1;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          done_en   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      lat_waddr  <= '0;
      lat_wen    <= 1'b0;
      lat_load   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= memwrite_in;
        dmem_addr  <= aluout_in;
        dmem_wdata <= rdata2_in;
        lat_waddr  <= waddr_in;
        lat_wen    <= wen_in;
        lat_load   <= is_load(memwrite_in, memtoreg_in);
      end else if (done_en || abort) begin
        dmem_req <= 1'b0;
      end
      if (abort) err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with the MEM/WB pipeline register; request sequencing lives in mem_req_fsm.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DSIZE   = mem_wb_stage_pkg::DSIZE,
  parameter int ASIZE   = mem_wb_stage_pkg::ASIZE,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             memwrite_in,
  input  logic             memtoreg_in,
  input  logic             wen_in,
  output logic             stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DSIZE-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic [DSIZE-1:0] wb_data_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
  output logic             err
);

  logic             pass_en, done_en, lat_wen, lat_load;
  logic [ASIZE-1:0] lat_waddr;

  mem_req_fsm #(
    .DSIZE  (DSIZE),
    .ASIZE  (ASIZE),
    .TIMEOUT(TIMEOUT)
  ) u_req (
    .clk        (clk),
    .rst        (rst),
    .aluout_in  (aluout_in),
    .rdata2_in  (rdata2_in),
    .waddr_in   (waddr_in),
    .memwrite_in(memwrite_in),
    .memtoreg_in(memtoreg_in),
    .wen_in     (wen_in),
    .dmem_ack   (dmem_ack),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .err        (err),
    .pass_en    (pass_en),
    .done_en    (done_en),
    .lat_waddr  (lat_waddr),
    .lat_wen    (lat_wen),
    .lat_load   (lat_load)
  );

  // Anything other than a pass-through or a completed access loads a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_out <= '0;
      waddr_out   <= '0;
      wen_out     <= 1'b0;
    end else if (pass_en) begin
      wb_data_out <= aluout_in;
      waddr_out   <= waddr_in;
      wen_out     <= wen_in;
    end else if (done_en) begin
      wb_data_out <= lat_load ? dmem_rdata : dmem_addr;
      waddr_out   <= lat_waddr;
      wen_out     <= lat_load & lat_wen;
    end else begin
      wen_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed instructions, a behavioural memory responder, write-back monitor.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aluout_in, rdata2_in;
  logic [3:0]  waddr_in;
  logic        memwrite_in, memtoreg_in, wen_in;
  logic        stall, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata = '0;
  logic [15:0] wb_data_out;
  logic [3:0]  waddr_out;
  logic        wen_out, err;

  logic r_ack = 1'b0;
  logic m_ack = 1'b0;
  assign dmem_ack = r_ack | m_ack;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .aluout_in(aluout_in), .rdata2_in(rdata2_in), .waddr_in(waddr_in),
    .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in), .wen_in(wen_in),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_data_out(wb_data_out), .waddr_out(waddr_out), .wen_out(wen_out), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  addr;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         exp_e;
  logic [15:0] resp_q[$];
  int          resp_delay = 0;
  int          wait_cnt = 0;
  bit          ack_done = 1'b0;
  int          req_rises = 0;
  logic        req_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: acks resp_delay cycles after dmem_req rises; resp_delay < 0 never acks.
  always @(negedge clk) begin
    r_ack = 1'b0;
    if (dmem_req !== 1'b1) begin
      wait_cnt = 0;
      ack_done = 1'b0;
    end else if (!ack_done) begin
      if (resp_delay >= 0 && wait_cnt == resp_delay) begin
        r_ack      = 1'b1;
        dmem_rdata = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0000;
        ack_done   = 1'b1;
      end else begin
        wait_cnt++;
      end
    end
    if (dmem_req === 1'b1 && req_d !== 1'b1) req_rises++;
    req_d = dmem_req;
  end

  // Write-back monitor: every asserted wen_out must match the oldest expected write-back.
  always @(negedge clk) begin
    if (rst === 1'b1 && wen_out !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got write-back r%0d=0x%0h, expected none", waddr_out, wb_data_out);
      end else begin
        exp_e = exp_q.pop_front();
        check("wb_data", {16'h0, wb_data_out}, {16'h0, exp_e.data});
        check("wb_addr", {28'h0, waddr_out}, {28'h0, exp_e.addr});
      end
    end
  end

  task automatic drive(input logic [15:0] alu, input logic [15:0] rd2, input logic [3:0] wa,
                       input logic mw, input logic mtr, input logic we);
    aluout_in = alu; rdata2_in = rd2; waddr_in = wa;
    memwrite_in = mw; memtoreg_in = mtr; wen_in = we;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    drive(16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  // Presents one instruction and holds it until stall drops; returns just after the accepting edge.
  task automatic issue(input logic [15:0] alu, input logic [15:0] rd2, input logic [3:0] wa,
                       input logic mw, input logic mtr, input logic we,
                       input int exp_stall, input string tag, output int req_cyc);
    int cycles = 0;
    bit done = 1'b0;
    req_cyc = 0;
    @(negedge clk);
    drive(alu, rd2, wa, mw, mtr, we);
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (dmem_req === 1'b1) begin
        req_cyc++;
        check({tag, "_dmem_addr"}, {16'h0, dmem_addr}, {16'h0, alu});
        check({tag, "_dmem_we"}, {31'h0, dmem_we}, {31'h0, mw});
        if (mw) check({tag, "_dmem_wdata"}, {16'h0, dmem_wdata}, {16'h0, rd2});
      end
      if (stall === 1'b1) begin
        cycles++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_stall_bound: got stall still high after 40 cycles, expected release", tag);
    end
    @(posedge clk);
    check({tag, "_stall_cycles"}, cycles, exp_stall);
  endtask

  int rc;
  int rises0;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish by 100000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_stall", {31'h0, stall}, 0);
    check("rst_dmem_req", {31'h0, dmem_req}, 0);
    check("rst_dmem_we", {31'h0, dmem_we}, 0);
    check("rst_dmem_addr", {16'h0, dmem_addr}, 0);
    check("rst_dmem_wdata", {16'h0, dmem_wdata}, 0);
    check("rst_wb_data", {16'h0, wb_data_out}, 0);
    check("rst_waddr", {28'h0, waddr_out}, 0);
    check("rst_wen", {31'h0, wen_out}, 0);
    check("rst_err", {31'h0, err}, 0);
    rst = 1'b1;

    // ALU op: one-cycle latency, no stall
    exp_q.push_back('{16'h1234, 4'd5});
    issue(16'h1234, 16'h0, 4'd5, 1'b0, 1'b0, 1'b1, 0, "alu", rc);
    #1;
    check("alu_wen", {31'h0, wen_out}, 1);
    check("alu_data", {16'h0, wb_data_out}, 32'h1234);
    idle(1);

    // Load, ack on first BUSY cycle
    resp_delay = 0;
    resp_q.push_back(16'hBEEF);
    exp_q.push_back('{16'hBEEF, 4'd3});
    issue(16'h0040, 16'h0, 4'd3, 1'b0, 1'b1, 1'b1, 1, "load", rc);
    check("load_req_cycles", rc, 1);
    #1;
    check("load_wen", {31'h0, wen_out}, 1);
    check("load_req_drop", {31'h0, dmem_req}, 0);
    idle(2);

    // Store, ack after three extra cycles; never writes back
    resp_delay = 3;
    issue(16'h0010, 16'h00AA, 4'd9, 1'b1, 1'b0, 1'b1, 4, "store", rc);
    check("store_req_cycles", rc, 4);
    #1;
    check("store_wen", {31'h0, wen_out}, 0);
    check("store_wb_data", {16'h0, wb_data_out}, 32'h0010);
    idle(2);

    // Store with memtoreg also set is treated as a store
    resp_delay = 0;
    issue(16'h0018, 16'h0055, 4'd10, 1'b1, 1'b1, 1'b1, 1, "st_both", rc);
    #1;
    check("st_both_wen", {31'h0, wen_out}, 0);
    idle(1);

    // Watchdog: no ack, TIMEOUT=4
    resp_delay = -1;
    issue(16'h0020, 16'h0, 4'd4, 1'b0, 1'b1, 1'b1, 4, "tmo", rc);
    check("tmo_req_cycles", rc, 4);
    #1;
    check("tmo_err", {31'h0, err}, 1);
    check("tmo_req_drop", {31'h0, dmem_req}, 0);
    check("tmo_wen", {31'h0, wen_out}, 0);
    idle(1);
    resp_delay = 0;
    exp_q.push_back('{16'h5678, 4'd2});
    issue(16'h5678, 16'h0, 4'd2, 1'b0, 1'b0, 1'b1, 0, "alu2", rc);
    #1;
    check("alu2_wen", {31'h0, wen_out}, 1);
    check("alu2_err_sticky", {31'h0, err}, 1);
    idle(1);

    // Asynchronous reset in the middle of BUSY, then a stray ack
    resp_delay = -1;
    @(negedge clk);
    drive(16'h0070, 16'h0, 4'd8, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("rbusy_req", {31'h0, dmem_req}, 1);
    drive(16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rbusy_req_clr", {31'h0, dmem_req}, 0);
    check("rbusy_addr_clr", {16'h0, dmem_addr}, 0);
    check("rbusy_err_clr", {31'h0, err}, 0);
    check("rbusy_stall_clr", {31'h0, stall}, 0);
    check("rbusy_wb_clr", {16'h0, wb_data_out}, 0);
    @(negedge clk);
    rst = 1'b1;
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("late_ack_wen", {31'h0, wen_out}, 0);
    check("late_ack_req", {31'h0, dmem_req}, 0);
    resp_delay = 1;

    // Back-to-back loads, one extra ack cycle each
    rises0 = req_rises;
    resp_q.push_back(16'h1111);
    resp_q.push_back(16'h2222);
    exp_q.push_back('{16'h1111, 4'd6});
    exp_q.push_back('{16'h2222, 4'd7});
    issue(16'h0050, 16'h0, 4'd6, 1'b0, 1'b1, 1'b1, 2, "ld1", rc);
    issue(16'h0060, 16'h0, 4'd7, 1'b0, 1'b1, 1'b1, 2, "ld2", rc);
    idle(3);
    check("ldld_requests", req_rises - rises0, 2);
    check("wb_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
